// File: rtl/video_cap2.sv
// video_cap2: AXI4-Stream video sink that grabs one IMGW x IMGH window of an
// SCRW x SCRH frame into a single-port BRAM write port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse arming a single-frame capture
//   offw, offh        window x/y offset, latched when start is accepted
//   s_axis_*          slave video stream (tuser = SOF, tlast = EOL)
//   bram_we_o/addr_o/data_o  BRAM write port, one cycle after the pixel beat
//   busy              high while waiting for SOF or capturing
//   done              one-cycle pulse when the captured frame ends
//   err_sof, err_eol  sticky framing errors, cleared by the next start
module video_cap2 #(
    parameter int unsigned DATAW = 24,
    parameter int unsigned SCRW  = 1920,
    parameter int unsigned SCRH  = 1080,
    parameter int unsigned IMGW  = 320,
    parameter int unsigned IMGH  = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [12:0]      offw,
    input  logic [12:0]      offh,
    input  logic [DATAW-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic             bram_we_o,
    output logic [16:0]      bram_addr_o,
    output logic [DATAW-1:0] bram_data_o,
    output logic             busy,
    output logic             done,
    output logic             err_sof,
    output logic             err_eol
);

    localparam int unsigned CW = 13;  // pixel/line counter width
    localparam int unsigned WW = 14;  // window compare width (no wrap)
    localparam int unsigned AW = 17;  // BRAM address width

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     offw_q, offw_d, offh_q, offh_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic [AW-1:0]     waddr_q, waddr_d, row_base_q, row_base_d;
    logic              tready_q, tready_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATAW-1:0]  data_q, data_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              err_sof_q, err_sof_d, err_eol_q, err_eol_d;

    // Per-beat decode: a tuser beat is always pixel (0,0) with fresh row/write bases
    logic              beat_c, proc_c, at_last_c, eol_c, in_x_c, in_y_c;
    logic [CW-1:0]     px_c, py_c;
    logic [AW-1:0]     base_c, wbase_c, wr_addr_c;
    logic [WW-1:0]     x_lo_c, x_hi_c, y_lo_c, y_hi_c;

    always_comb begin
        beat_c    = s_axis_tvalid & tready_q;
        proc_c    = beat_c & (((state_q == WAIT_SOF) & s_axis_tuser) | (state_q == CAPTURE));
        px_c      = s_axis_tuser ? '0 : x_q;
        py_c      = s_axis_tuser ? '0 : y_q;
        base_c    = s_axis_tuser ? '0 : row_base_q;
        wbase_c   = s_axis_tuser ? '0 : waddr_q;
        x_lo_c    = {1'b0, offw_q};
        x_hi_c    = x_lo_c + WW'(IMGW);
        y_lo_c    = {1'b0, offh_q};
        y_hi_c    = y_lo_c + WW'(IMGH);
        in_x_c    = ({1'b0, px_c} >= x_lo_c) && ({1'b0, px_c} < x_hi_c);
        in_y_c    = ({1'b0, py_c} >= y_lo_c) && ({1'b0, py_c} < y_hi_c);
        at_last_c = (px_c == CW'(SCRW - 1));
        eol_c     = s_axis_tlast | at_last_c;
        // First in-window pixel of a line always sits at x == offw
        wr_addr_c = (px_c == offw_q) ? base_c : wbase_c;
    end

    // Next-state and next-register logic
    always_comb begin
        state_d    = state_q;
        offw_d     = offw_q;
        offh_d     = offh_q;
        x_d        = x_q;
        y_d        = y_q;
        waddr_d    = waddr_q;
        row_base_d = row_base_q;
        tready_d   = 1'b1;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        err_sof_d  = err_sof_q;
        err_eol_d  = err_eol_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WAIT_SOF;
                    offw_d     = offw;
                    offh_d     = offh;
                    err_sof_d  = 1'b0;
                    err_eol_d  = 1'b0;
                    x_d        = '0;
                    y_d        = '0;
                    waddr_d    = '0;
                    row_base_d = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        if (proc_c) begin
            if (state_q == WAIT_SOF) begin
                state_d = CAPTURE;
            end else if (s_axis_tuser) begin
                err_sof_d = 1'b1;
            end

            row_base_d = base_c;
            if (in_x_c && in_y_c) begin
                we_d    = 1'b1;
                addr_d  = wr_addr_c;
                data_d  = s_axis_tdata;
                waddr_d = wr_addr_c + AW'(1);
            end else begin
                waddr_d = wbase_c;
            end

            if (eol_c) begin
                if (s_axis_tlast != at_last_c) begin
                    err_eol_d = 1'b1;
                end
                x_d = '0;
                y_d = py_c + CW'(1);
                if (in_y_c) begin
                    row_base_d = base_c + AW'(IMGW);
                end
                if (py_c == CW'(SCRH - 1)) begin
                    state_d = DONE;
                end
            end else begin
                x_d = px_c + CW'(1);
                y_d = py_c;
            end
        end

        busy_d = (state_d == WAIT_SOF) || (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            offw_q     <= '0;
            offh_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            waddr_q    <= '0;
            row_base_q <= '0;
            tready_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_sof_q  <= 1'b0;
            err_eol_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            offw_q     <= offw_d;
            offh_q     <= offh_d;
            x_q        <= x_d;
            y_q        <= y_d;
            waddr_q    <= waddr_d;
            row_base_q <= row_base_d;
            tready_q   <= tready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_sof_q  <= err_sof_d;
            err_eol_q  <= err_eol_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign bram_we_o     = we_q;
    assign bram_addr_o   = addr_q;
    assign bram_data_o   = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_sof       = err_sof_q;
    assign err_eol       = err_eol_q;

endmodule

// File: tb/tb_video_cap2.sv
// tb_video_cap2: table-driven and randomized checks of video_cap2 against a
// position-based reference model (closed-form window addresses).
module tb_video_cap2;

    localparam int unsigned DATAW = 16;
    localparam int unsigned SCRW  = 16;
    localparam int unsigned SCRH  = 8;
    localparam int unsigned IMGW  = 4;
    localparam int unsigned IMGH  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [12:0]      offw, offh;
    logic [DATAW-1:0] tdata;
    logic             tvalid, tready, tuser, tlast;
    logic             we;
    logic [16:0]      addr;
    logic [DATAW-1:0] wdata;
    logic             busy, done, err_sof, err_eol;

    always #5 clk = ~clk;

    video_cap2 #(.DATAW(DATAW), .SCRW(SCRW), .SCRH(SCRH), .IMGW(IMGW), .IMGH(IMGH)) dut (
        .clk(clk), .rst(rst), .start(start), .offw(offw), .offh(offh),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .s_axis_tuser(tuser), .s_axis_tlast(tlast),
        .bram_we_o(we), .bram_addr_o(addr), .bram_data_o(wdata),
        .busy(busy), .done(done), .err_sof(err_sof), .err_eol(err_eol)
    );

    typedef struct {
        int offw, offh, njunk, short_line, short_len, notlast_line, sof_line, start_mid;
        int exp_nw, exp_sof, exp_eol, exp_addr0, exp_data0;
    } vec_t;

    typedef struct { logic [DATAW-1:0] d; logic u; logic l; } beat_t;
    typedef struct { logic [16:0] a; logic [DATAW-1:0] d; } wr_t;

    beat_t beats[$];
    wr_t   got[$];
    wr_t   exp_q[$];
    int    exp_sof, exp_eol, exp_done;

    int n_vec = 0, n_bad = 0;
    int done_cnt = 0, busy_drop = 0;
    bit in_frame = 0;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (we) got.push_back('{a: addr, d: wdata});
        if (done) begin
            done_cnt++;
            in_frame = 0;
        end else if (in_frame && !busy) begin
            busy_drop++;
        end
    end

    task automatic drive(input logic v, input logic u, input logic l,
                         input logic [DATAW-1:0] d, input logic st);
        @(posedge clk);
        #1;
        tvalid = v; tuser = u; tlast = l; tdata = d; start = st;
    endtask

    task automatic push_line(input int ln, input int len, input bit nolast, input bit sof);
        beat_t b;
        for (int x = 0; x < len; x++) begin
            b.d = DATAW'({8'(ln), 8'(x)});
            b.u = sof && (x == 0);
            b.l = (x == len - 1) && !nolast;
            beats.push_back(b);
        end
    endtask

    task automatic build_frame(input vec_t v);
        beat_t b;
        int first_lines;
        beats.delete();
        for (int i = 0; i < v.njunk; i++) begin
            b.d = DATAW'($urandom); b.u = 1'b0; b.l = 1'b0;
            beats.push_back(b);
        end
        first_lines = (v.sof_line >= 0) ? v.sof_line : int'(SCRH);
        for (int ln = 0; ln < first_lines; ln++)
            push_line(ln, (ln == v.short_line) ? v.short_len : int'(SCRW),
                      ln == v.notlast_line, ln == 0);
        if (v.sof_line >= 0)
            for (int ln = 0; ln < int'(SCRH); ln++) push_line(ln, SCRW, 0, ln == 0);
    endtask

    // Reference: walk beats as screen positions; address is (y-offh)*IMGW + (x-offw)
    task automatic model(input int ow, input int oh);
        int px, py;
        bit cap, last;
        exp_q.delete();
        exp_sof = 0; exp_eol = 0; exp_done = 0;
        cap = 0; px = 0; py = 0;
        foreach (beats[i]) begin
            if (exp_done != 0) break;
            if (!cap) begin
                if (!beats[i].u) continue;
                cap = 1; px = 0; py = 0;
            end else if (beats[i].u) begin
                exp_sof = 1; px = 0; py = 0;
            end
            if (px >= ow && px < ow + int'(IMGW) && py >= oh && py < oh + int'(IMGH))
                exp_q.push_back('{a: 17'((py - oh) * int'(IMGW) + (px - ow)), d: beats[i].d});
            last = (px == int'(SCRW) - 1);
            if (beats[i].l || last) begin
                if (beats[i].l != last) exp_eol = 1;
                if (py == int'(SCRH) - 1) exp_done = 1;
                px = 0; py++;
            end else begin
                px++;
            end
        end
    endtask

    task automatic arm(input int ow, input int oh);
        // Beats (even with tuser) seen before start must be discarded
        drive(1, 1, 0, 16'hABCD, 0);
        drive(1, 0, 1, 16'h1234, 0);
        offw = 13'(ow); offh = 13'(oh);
        drive(0, 0, 0, '0, 1);
        drive(0, 0, 0, '0, 0);
        in_frame = 1;
        check("err_clear_on_start", {err_sof, err_eol}, 2'b00);
        check("busy_after_start", busy, 1'b1);
        // Offsets must have been latched; scramble the inputs
        offw = 13'($urandom); offh = 13'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input bit use_tbl, input bit gaps);
        int dc0, mid;
        build_frame(v);
        model(v.offw, v.offh);
        got.delete();
        busy_drop = 0;
        dc0 = done_cnt;
        arm(v.offw, v.offh);
        mid = beats.size() / 2;
        foreach (beats[i]) begin
            if (gaps) repeat ($urandom_range(0, 1)) drive(0, 0, 0, '0, 0);
            drive(1, beats[i].u, beats[i].l, beats[i].d, (v.start_mid != 0) && (i == mid));
        end
        drive(0, 0, 0, '0, 0);
        for (int c = 0; c < 20 && done_cnt == dc0; c++) @(negedge clk);
        in_frame = 0;
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - dc0, exp_done);
        check("busy_drop", busy_drop, 0);
        check("nwrites", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check("wr_addr", got[i].a, exp_q[i].a);
            check("wr_data", got[i].d, exp_q[i].d);
        end
        check("err_sof", err_sof, exp_sof);
        check("err_eol", err_eol, exp_eol);
        if (use_tbl) begin
            check("tbl_nwrites", got.size(), v.exp_nw);
            check("tbl_err_sof", err_sof, v.exp_sof);
            check("tbl_err_eol", err_eol, v.exp_eol);
            if (v.exp_nw > 0 && got.size() > 0) begin
                check("tbl_addr0", got[0].a, v.exp_addr0);
                check("tbl_data0", got[0].d, v.exp_data0);
            end
        end
    endtask

    task automatic reset_mid_capture();
        vec_t v;
        int nbefore, dc0, cut;
        v = tbl[0];
        build_frame(v);
        got.delete();
        dc0 = done_cnt;
        arm(v.offw, v.offh);
        cut = 2 * int'(SCRW) + 5;
        for (int i = 0; i < cut; i++) drive(1, beats[i].u, beats[i].l, beats[i].d, 0);
        @(posedge clk);
        #2;
        in_frame = 0;
        nbefore = got.size();
        rst = 1'b1;
        #1;
        check("rst_async_outputs",
              {we, addr, wdata, busy, done, err_sof, err_eol, tready}, 64'd0);
        drive(0, 0, 0, '0, 0);
        drive(0, 0, 0, '0, 0);
        rst = 1'b0;
        for (int i = cut; i < beats.size(); i++) drive(1, beats[i].u, beats[i].l, beats[i].d, 0);
        drive(0, 0, 0, '0, 0);
        repeat (5) @(negedge clk);
        check("rst_no_writes", got.size(), nbefore);
        check("rst_no_done", done_cnt - dc0, 0);
        check("rst_tready", tready, 1'b1);
        check("rst_busy", busy, 1'b0);
    endtask

    initial begin
        vec_t rv;
        //          offw offh junk sl  slen nl  sof mid  nw sof eol a0 d0
        tbl[0] = '{  3,  2,  0, -1,  0, -1, -1, 0,   8, 0, 0, 0, 'h0203};
        tbl[1] = '{  3,  2,  5, -1,  0, -1, -1, 0,   8, 0, 0, 0, 'h0203};
        tbl[2] = '{ 14,  7,  0, -1,  0, -1, -1, 0,   2, 0, 0, 0, 'h070E};
        tbl[3] = '{  3,  2,  0,  2, 10, -1, -1, 0,   8, 0, 1, 0, 'h0203};
        tbl[4] = '{  3,  2,  0, -1,  0, -1,  5, 0,  16, 1, 0, 0, 'h0203};
        tbl[5] = '{ 13,  6,  0, -1,  0, -1, -1, 0,   6, 0, 0, 0, 'h060D};
        tbl[6] = '{  0,  0,  0, -1,  0,  1, -1, 0,   8, 0, 1, 0, 'h0000};
        tbl[7] = '{ 20,  0,  0, -1,  0, -1, -1, 0,   0, 0, 0, 0, 0};
        tbl[8] = '{  3,  2,  2, -1,  0, -1, -1, 1,   8, 0, 0, 0, 'h0203};
        tbl[9] = '{  0,  7,  0,  7,  2, -1, -1, 0,   2, 0, 1, 0, 'h0700};

        rst = 1'b1; start = 0; offw = '0; offh = '0;
        tvalid = 0; tuser = 0; tlast = 0; tdata = '0;
        #12;
        check("reset_state",
              {we, addr, wdata, busy, done, err_sof, err_eol, tready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, '0, 0);
        check("tready_after_reset", tready, 1'b1);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], 1, i[0]);

        reset_mid_capture();
        run_vec(tbl[0], 1, 1);

        for (int i = 0; i < 8; i++) begin
            rv = tbl[0];
            rv.offw = $urandom_range(0, 18);
            rv.offh = $urandom_range(0, 9);
            rv.njunk = $urandom_range(0, 3);
            rv.short_line = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
            rv.short_len = $urandom_range(1, 15);
            rv.sof_line = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : -1;
            run_vec(rv, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/video_cap2.md
Name: video_cap2

Overview:
AXI4-Stream video sink: the receive-side counterpart of the team's BRAM-backed video image source. Accepts a full SCRW x SCRH frame on a slave AXI4-Stream port (tuser = start-of-frame, tlast = end-of-line). Writes one IMGW x IMGH window of that frame, at a programmable offset, into a single-port BRAM through a write port. Used for frame grab / loopback checking of the video pipeline.

Parameters:
DATAW, 24, pixel/tdata width in bits (multiple of 8)
SCRW, 1920, pixels per line of the incoming frame
SCRH, 1080, lines per incoming frame
IMGW, 320, captured window width in pixels
IMGH, 240, captured window height in lines (IMGW*IMGH <= 2^17)

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: arm a single-frame capture
offw  in  13  window x offset, latched on accepted start
offh  in  13  window y offset, latched on accepted start
s_axis_tdata  in  DATAW  pixel data
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  sink ready
s_axis_tuser  in  1  start of frame, first pixel only
s_axis_tlast  in  1  end of line, last pixel of each line
bram_we_o  out  1  BRAM write enable
bram_addr_o  out  17  BRAM word address
bram_data_o  out  DATAW  BRAM write data
busy  out  1  high in WAIT_SOF or CAPTURE
done  out  1  one-cycle pulse at end of captured frame
err_sof  out  1  sticky: unexpected tuser mid-frame
err_eol  out  1  sticky: tlast early or missing

Behaviour:
- Reset (async assert, release on clk): state IDLE. tready, bram_we_o, bram_addr_o, bram_data_o, busy, done, err_sof, err_eol all 0. x, y and write-address counters are 0.
- Outside reset, tready = 1 in every state; the sink never back-pressures. A beat is accepted when tvalid & tready. Beats accepted in IDLE are discarded.
- FSM states: IDLE, WAIT_SOF, CAPTURE, DONE.
  - IDLE -> WAIT_SOF on start. This latches offw/offh, clears err_sof/err_eol, sets x=y=0 and waddr=0.
  - WAIT_SOF: beats without tuser are discarded. A beat with tuser is pixel (0,0); it is processed as a CAPTURE beat and the FSM enters CAPTURE.
  - CAPTURE: each beat is pixel (x,y).
    - Beat with tlast: if x != SCRW-1, set err_eol. x <- 0, y <- y+1.
    - Beat at x == SCRW-1 without tlast: set err_eol. x <- 0, y <- y+1.
    - Any other beat: x <- x+1.
    - End of line with y == SCRH-1 -> DONE.
  - Beat with tuser in CAPTURE (not the first beat): set err_sof. Resync: treat that beat as pixel (0,0) and reset waddr to 0.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start while busy or in DONE is ignored.
- Window test: pixel is in-window when offw <= x < offw+IMGW and offh <= y < offh+IMGH. Compare at 14 bits so no wrap. A window extending past SCRW/SCRH is clipped; that gives fewer writes, and addresses stay packed per the rule below.
- Write path, latency 1. The cycle after an in-window beat is accepted: bram_we_o=1, bram_data_o=tdata, bram_addr_o=waddr. waddr increments per write.
  - At the first in-window pixel of each line, waddr is set to (y-offh)*IMGW, so clipped lines keep row alignment.
  - Row base is a running accumulator (+IMGW per window line). No multiplier.
- bram_we_o is 0 on all other cycles. bram_addr_o and bram_data_o hold their last values.
- busy is registered. It rises the cycle after start and falls on entry to DONE.
- Reset mid-capture aborts immediately. No further writes occur, and done is not pulsed.

Test Plan:
- SCRW=16, SCRH=8, IMGW=4, IMGH=2, offw=3, offh=2, pixel data = {y,x}: start, send a clean frame -> exactly 8 writes. Addresses 0..7, data {2,3},{2,4},{2,5},{2,6},{3,3}..{3,6}. One done pulse; errors 0.
- Same config, send 5 non-tuser beats before the frame -> beats ignored, capture identical to test 1, busy high from start to done.
- offw=14, offh=7 (window clipped): clean frame -> 2 writes, data {7,14},{7,15}, addresses 0,1. done pulses.
- tlast at x=9 on line 2: err_eol=1 and y advances. Frame still completes with done; err_eol stays 1 until next start.
- tuser reasserted at line 5 -> err_sof=1, counters resync to (0,0), waddr restarts at 0.
- Assert rst during line 2 of capture -> all outputs 0 asynchronously, no writes after release, no done. A subsequent start captures normally.
